// File: rtl/gbc_vga_scanout.sv
// 160x144 RGB332 VRAM to 640x480@60 VGA scanout, x3 upscale, centred with a solid border.
// Optional GBC_VGA_SCANLINE_EN: half-intensity last sub-row of every scaled source row.
module gbc_vga_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SRC_W     = 160,
  parameter int SRC_H     = 144,
  parameter int SCALE     = 3,
  parameter logic [7:0] BORDER_COLOR = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [14:0] o_vramReadAddr,
  input  logic [7:0]  i_vramData,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [2:0]  o_red,
  output logic [2:0]  o_green,
  output logic [1:0]  o_blue,
  output logic        o_frameStart
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HOFF    = (H_VISIBLE - SRC_W * SCALE) / 2;
  localparam int VOFF    = (V_VISIBLE - SRC_H * SCALE) / 2;

  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0]  V_VIS     = 10'(V_VISIBLE);
  localparam logic [9:0]  HS_BEG    = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]  HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  VS_BEG    = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0]  WX_BEG    = 10'(HOFF);
  localparam logic [9:0]  WX_LAST   = 10'(HOFF + SRC_W * SCALE - 1);
  localparam logic [9:0]  WY_BEG    = 10'(VOFF);
  localparam logic [9:0]  WY_END    = 10'(VOFF + SRC_H * SCALE);
  localparam logic [1:0]  SUB_LAST  = 2'(SCALE - 1);
  localparam logic [14:0] LINE_STEP = 15'(SRC_W);

  logic [9:0]  r_hCount, r_vCount;
  logic [1:0]  r_xSub, r_ySub;
  logic [7:0]  r_srcX;
  logic [14:0] r_lineBase;
  logic        r_win1, r_vis1, r_hs1, r_vs1, r_fs1;
  logic        r_win2;
  logic [7:0]  r_fill2;
`ifdef GBC_VGA_SCANLINE_EN
  logic        r_scan1, r_scan2;
`endif

  logic        w_visible, w_window, w_hsync, w_vsync;
  logic [7:0]  w_pix, w_rgb;

  assign w_visible = (r_hCount < H_VIS) && (r_vCount < V_VIS);
  assign w_window  = (r_hCount >= WX_BEG) && (r_hCount <= WX_LAST) &&
                     (r_vCount >= WY_BEG) && (r_vCount < WY_END);
  assign w_hsync   = !((r_hCount >= HS_BEG) && (r_hCount < HS_END));
  assign w_vsync   = !((r_vCount >= VS_BEG) && (r_vCount < VS_END));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hCount       <= '0;
      r_vCount       <= '0;
      r_xSub         <= '0;
      r_ySub         <= '0;
      r_srcX         <= '0;
      r_lineBase     <= '0;
      o_vramReadAddr <= '0;
      r_win1         <= 1'b0;
      r_vis1         <= 1'b0;
      r_hs1          <= 1'b1;
      r_vs1          <= 1'b1;
      r_fs1          <= 1'b0;
      r_win2         <= 1'b0;
      r_fill2        <= '0;
      o_hsync        <= 1'b1;
      o_vsync        <= 1'b1;
      o_frameStart   <= 1'b0;
`ifdef GBC_VGA_SCANLINE_EN
      r_scan1        <= 1'b0;
      r_scan2        <= 1'b0;
`endif
    end else begin
      if (r_hCount == H_LAST) begin
        r_hCount <= '0;
        r_vCount <= (r_vCount == V_LAST) ? '0 : r_vCount + 10'd1;
      end else begin
        r_hCount <= r_hCount + 10'd1;
      end

      // x state idles at 0 outside the window so every window line starts at srcX=0
      if (w_window) begin
        if (r_xSub == SUB_LAST) begin
          r_xSub <= '0;
          r_srcX <= r_srcX + 8'd1;
        end else begin
          r_xSub <= r_xSub + 2'd1;
        end
      end else begin
        r_xSub <= '0;
        r_srcX <= '0;
      end

      if (r_vCount == '0) begin
        r_ySub     <= '0;
        r_lineBase <= '0;
      end else if (w_window && (r_hCount == WX_LAST)) begin
        if (r_ySub == SUB_LAST) begin
          r_ySub     <= '0;
          r_lineBase <= r_lineBase + LINE_STEP;
        end else begin
          r_ySub <= r_ySub + 2'd1;
        end
      end

      o_vramReadAddr <= w_window ? (r_lineBase + 15'(r_srcX)) : '0;

      r_win1 <= w_window;
      r_vis1 <= w_visible;
      r_hs1  <= w_hsync;
      r_vs1  <= w_vsync;
      r_fs1  <= (r_hCount == '0) && (r_vCount == '0);

      r_win2       <= r_win1;
      r_fill2      <= r_vis1 ? BORDER_COLOR : 8'h00;
      o_hsync      <= r_hs1;
      o_vsync      <= r_vs1;
      o_frameStart <= r_fs1;
`ifdef GBC_VGA_SCANLINE_EN
      r_scan1 <= w_window && (r_ySub == SUB_LAST);
      r_scan2 <= r_scan1;
`endif
    end
  end

  // The VRAM output register acts as the pixel register; only the select is ours.
  always_comb begin
    w_pix = i_vramData;
`ifdef GBC_VGA_SCANLINE_EN
    if (r_scan2) w_pix = {1'b0, i_vramData[7:6], 1'b0, i_vramData[4:3], 1'b0, i_vramData[1]};
`endif
    w_rgb = r_win2 ? w_pix : r_fill2;
  end

  assign o_red   = w_rgb[7:5];
  assign o_green = w_rgb[4:2];
  assign o_blue  = w_rgb[1:0];

endmodule

// File: tb/tb_gbc_vga_scanout.sv
// Bench for gbc_vga_scanout: a full-size instance for the real raster and a shrunken-raster
// instance (random resets) so whole frames fit in a short run.
module tb_gbc_vga_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [14:0] addr_a, addr_b;
  logic [7:0]  q_a, q_b;
  logic        hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;
  logic [2:0]  r_a, g_a, r_b, g_b;
  logic [1:0]  b_a, b_b;

  logic [7:0] mem_a [0:32767];
  logic [7:0] mem_b [0:32767];

  always @(posedge clk) begin
    q_a <= mem_a[addr_a];
    q_b <= mem_b[addr_b];
  end

  gbc_vga_scanout #(.BORDER_COLOR(8'hE3)) u_big (
    .i_clk(clk), .i_rst(rst_a), .o_vramReadAddr(addr_a), .i_vramData(q_a),
    .o_hsync(hs_a), .o_vsync(vs_a), .o_red(r_a), .o_green(g_a), .o_blue(b_a),
    .o_frameStart(fs_a));

  gbc_vga_scanout #(
    .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_VISIBLE(30), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SRC_W(10), .SRC_H(8), .SCALE(3), .BORDER_COLOR(8'hE3)
  ) u_small (
    .i_clk(clk), .i_rst(rst_b), .o_vramReadAddr(addr_b), .i_vramData(q_b),
    .o_hsync(hs_b), .o_vsync(vs_b), .o_red(r_b), .o_green(g_b), .o_blue(b_b),
    .o_frameStart(fs_b));

  int checks = 0;
  int errors = 0;
  int nprint = 0;
  bit done = 1'b0;

  // Expected outputs for raster position s (cycles since (0,0)), from the raster geometry.
  function automatic void model(input bit big, input int s, output logic [14:0] a,
                                output logic hs, output logic vs, output logic fs,
                                output logic [7:0] rgb);
    int hv, hf, hsw, hb, vv, vf, vsw, vb, sw, sh, ht, vt, hoff, voff, h, v;
    bit win, vis;
    logic [7:0] d;
    if (big) begin
      hv = 640; hf = 16; hsw = 96; hb = 48; vv = 480; vf = 10; vsw = 2; vb = 33; sw = 160; sh = 144;
    end else begin
      hv = 40; hf = 4; hsw = 6; hb = 6; vv = 30; vf = 2; vsw = 2; vb = 3; sw = 10; sh = 8;
    end
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    hoff = (hv - sw * 3) / 2;
    voff = (vv - sh * 3) / 2;
    h = s % ht;
    v = (s / ht) % vt;
    win = (h >= hoff) && (h < hoff + sw * 3) && (v >= voff) && (v < voff + sh * 3);
    vis = (h < hv) && (v < vv);
    a  = win ? 15'(((v - voff) / 3) * sw + (h - hoff) / 3) : 15'd0;
    hs = !((h >= hv + hf) && (h < hv + hf + hsw));
    vs = !((v >= vv + vf) && (v < vv + vf + vsw));
    fs = (h == 0) && (v == 0);
    if (win) begin
      d = big ? mem_a[a] : mem_b[a];
`ifdef GBC_VGA_SCANLINE_EN
      if (((v - voff) % 3) == 2) d = {3'(d[7:5] >> 1), 3'(d[4:2] >> 1), 2'(d[1:0] >> 1)};
`endif
      rgb = d;
    end else begin
      rgb = vis ? 8'hE3 : 8'h00;
    end
  endfunction

  // k = rising edges since reset release; address lags counters by 1, everything else by 2.
  task automatic check_dut(input bit big, input int k, input logic [14:0] aa, input logic hs,
                           input logic vs, input logic fs, input logic [7:0] rgb);
    logic [14:0] ea, xa;
    logic ehs, evs, efs, xhs, xvs, xfs;
    logic [7:0] ergb, xrgb;
    ea = '0;
    if (k > 0) model(big, k - 1, ea, xhs, xvs, xfs, xrgb);
    ehs = 1'b1; evs = 1'b1; efs = 1'b0; ergb = 8'h00;
    if (k >= 2) model(big, k - 2, xa, ehs, evs, efs, ergb);
    checks++;
    if ({aa, hs, vs, fs, rgb} !== {ea, ehs, evs, efs, ergb}) begin
      errors++;
      if (nprint < 20)
        $display("FAIL model_%s k=%0d addr/hs/vs/fs/rgb got %h/%b/%b/%b/%h expected %h/%b/%b/%b/%h",
                 big ? "big" : "small", k, aa, hs, vs, fs, rgb, ea, ehs, evs, efs, ergb);
      nprint++;
    end
  endtask

  task automatic lit(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  localparam int L = 800;
  int ka = 0, kb = 0;
  int a_low = 0, a_lastfall = -1, b_vlow = 0, b_lastfs = -1, b_frames = 0, b_max = 0;
  logic a_prev_hs = 1'b1, b_prev_vs = 1'b1;
  logic [7:0] rgb_a, rgb_b;

  always @(posedge clk) begin
    ka = rst_a ? 0 : ka + 1;
    kb = rst_b ? 0 : kb + 1;
    #1;
    rgb_a = {r_a, g_a, b_a};
    rgb_b = {r_b, g_b, b_b};
    check_dut(1'b1, ka, addr_a, hs_a, vs_a, fs_a, rgb_a);
    check_dut(1'b0, kb, addr_b, hs_b, vs_b, fs_b, rgb_b);

    if (rst_a) begin
      lit("reset_outputs", {4'd0, hs_a, vs_a, fs_a, addr_a[0], rgb_a}, 16'h0C00);
      a_low = 0; a_lastfall = -1; a_prev_hs = 1'b1;
    end else begin
      if (ka == 2) lit("framestart_after_reset", 16'(fs_a), 16'd1);
      if (ka == 3) lit("framestart_one_cycle", 16'(fs_a), 16'd0);
      if (ka - 1 == 24 * L + 80) lit("addr_24_80", 16'(addr_a), 16'd0);
      if (ka - 1 == 24 * L + 82) lit("addr_24_82", 16'(addr_a), 16'd0);
      if (ka - 1 == 24 * L + 83) lit("addr_24_83", 16'(addr_a), 16'd1);
      if (ka - 1 == 27 * L + 80) lit("addr_27_80", 16'(addr_a), 16'd160);
      if (ka - 1 == 24 * L + 600) lit("addr_outside", 16'(addr_a), 16'd0);
      if (ka - 2 == 24 * L + 83) lit("pix_24_83", 16'(rgb_a), 16'h01);
      if (ka - 2 == 10 * L + 300) lit("pix_top_border", 16'(rgb_a), 16'hE3);
      if (ka - 2 == 50 * L + 0) lit("pix_50_0", 16'(rgb_a), 16'hE3);
      if (ka - 2 == 50 * L + 79) lit("pix_50_79", 16'(rgb_a), 16'hE3);
      if (ka - 2 == 50 * L + 560) lit("pix_50_560", 16'(rgb_a), 16'hE3);
      if (ka - 2 == 50 * L + 639) lit("pix_50_639", 16'(rgb_a), 16'hE3);
      if (ka - 2 == 30 * L + 700) lit("pix_blank", 16'(rgb_a), 16'h00);
      if (ka - 2 == 27 * L + 365) lit("pix_27_365", 16'(rgb_a), 16'hFF);
`ifdef GBC_VGA_SCANLINE_EN
      if (ka - 2 == 29 * L + 365) lit("pix_29_365_scan", 16'(rgb_a), 16'h6D);
`else
      if (ka - 2 == 29 * L + 365) lit("pix_29_365", 16'(rgb_a), 16'hFF);
`endif
      if (!hs_a) a_low++;
      if (hs_a && !a_prev_hs) begin
        lit("hsync_width", 16'(a_low), 16'd96);
        a_low = 0;
      end
      if (!hs_a && a_prev_hs) begin
        if (a_lastfall >= 0) lit("line_period", 16'(ka - a_lastfall), 16'd800);
        a_lastfall = ka;
      end
      a_prev_hs = hs_a;
    end

    if (rst_b) begin
      b_vlow = 0; b_lastfs = -1; b_prev_vs = 1'b1;
    end else begin
      if (int'(addr_b) > b_max) b_max = int'(addr_b);
      if (fs_b) begin
        if (b_lastfs >= 0) begin
          lit("frame_period", 16'(kb - b_lastfs), 16'd2072);
          b_frames++;
        end
        b_lastfs = kb;
      end
      if (!vs_b) b_vlow++;
      if (vs_b && !b_prev_vs) begin
        lit("vsync_width", 16'(b_vlow), 16'd112);
        b_vlow = 0;
      end
      b_prev_vs = vs_b;
    end
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 32768; i++) begin
      mem_a[i] = 8'(i);
      mem_b[i] = 8'($urandom);
    end
    repeat (5) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    fork
      begin
        int gap;
        gap = 5000;
        while (!done) begin
          repeat (gap) @(negedge clk);
          if (done) break;
          rst_b = 1'b1;
          repeat ($urandom_range(1, 5)) @(negedge clk);
          rst_b = 1'b0;
          gap = $urandom_range(300, 7000);
        end
      end
    join_none
    repeat (1000) @(negedge clk);
    rst_a = 1'b1;
    repeat (5) @(negedge clk);
    rst_a = 1'b0;
    repeat (41000) @(negedge clk);
    done = 1'b1;
    lit("small_max_addr", 16'(b_max), 16'd79);
    lit("small_frames_seen", 16'(b_frames > 0), 16'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
